// File: rtl/cpa_sequencer.sv
// Segmented carry-propagate adder: one SEG_LEN-bit prefix-adder slice per cycle, IDLE/RUN/DONE handshake.
// Optional CPA_SEQUENCER_EARLY_TERM_EN: finish early once the carry dies and the remaining operand segments are zero.
module cpa_sequencer #(
    parameter int SEG_LEN  = 16,
    parameter int NUM_SEGS = 4,
    localparam int W       = SEG_LEN * NUM_SEGS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a_in,
    input  logic [W-1:0] b_in,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         busy
);

    localparam int IDXW = (NUM_SEGS > 1) ? $clog2(NUM_SEGS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_SEGS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state, state_nxt;
    logic [W-1:0]        a_reg, b_reg;
    logic [IDXW-1:0]     idx;
    logic                carry;
    logic [SEG_LEN-1:0]  a_seg, b_seg;
    logic [SEG_LEN:0]    seg_res;
    logic                last_seg;
    logic                accept;

    // Kogge-Stone generate/propagate prefix adder; returns {carry_out, sum}.
    function automatic logic [SEG_LEN:0] prefix_add(input logic [SEG_LEN-1:0] x,
                                                    input logic [SEG_LEN-1:0] y,
                                                    input logic ci);
        logic [SEG_LEN-1:0] p, g, pk, gn, pn, c;
        p     = x ^ y;
        g     = x & y;
        g[0]  = g[0] | (p[0] & ci);
        pk    = p;
        for (int d = 1; d < SEG_LEN; d = d * 2) begin
            gn = g;
            pn = pk;
            for (int i = d; i < SEG_LEN; i++) begin
                gn[i] = g[i] | (pk[i] & g[i-d]);
                pn[i] = pk[i] & pk[i-d];
            end
            g  = gn;
            pk = pn;
        end
        c[0] = ci;
        for (int i = 1; i < SEG_LEN; i++) c[i] = g[i-1];
        return {g[SEG_LEN-1], p ^ c};
    endfunction

    assign accept = (state == IDLE) && in_valid;

    always_comb begin
        a_seg = '0;
        b_seg = '0;
        for (int s = 0; s < NUM_SEGS; s++) begin
            if (idx == IDXW'(s)) begin
                a_seg = a_reg[s*SEG_LEN +: SEG_LEN];
                b_seg = b_reg[s*SEG_LEN +: SEG_LEN];
            end
        end
    end

    assign seg_res = prefix_add(a_seg, b_seg, carry);

`ifdef CPA_SEQUENCER_EARLY_TERM_EN
    logic hi_zero;

    // Once the carry is dead, zero upper operand segments can only add zero.
    always_comb begin
        hi_zero = 1'b1;
        for (int s = 0; s < NUM_SEGS; s++) begin
            if (s > int'(idx) &&
                ((a_reg[s*SEG_LEN +: SEG_LEN] | b_reg[s*SEG_LEN +: SEG_LEN]) != '0))
                hi_zero = 1'b0;
        end
    end

    assign last_seg = (idx == LAST_IDX) || (!seg_res[SEG_LEN] && hi_zero);
`else
    assign last_seg = (idx == LAST_IDX);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = RUN;
            RUN:     if (last_seg)  state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        busy      = (state == RUN);
        out_valid = (state == DONE);
    end

    // Operands are only meaningful after an accept, so they need no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_reg <= a_in;
            b_reg <= b_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx   <= '0;
            carry <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (accept) begin
            idx   <= '0;
            carry <= cin;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (state == RUN) begin
            for (int s = 0; s < NUM_SEGS; s++) begin
                if (idx == IDXW'(s)) sum[s*SEG_LEN +: SEG_LEN] <= seg_res[SEG_LEN-1:0];
            end
            carry <= seg_res[SEG_LEN];
            if (last_seg) cout <= seg_res[SEG_LEN];
            else          idx  <= idx + 1'b1;
        end
    end

endmodule

// File: tb/tb_cpa_sequencer.sv
// Directed and lightly randomised bench for cpa_sequencer (SEG_LEN=16, NUM_SEGS=4).
// Expected latency follows CPA_SEQUENCER_EARLY_TERM_EN when the bench is built with it.
module tb_cpa_sequencer;

    localparam int SEG_LEN  = 16;
    localparam int NUM_SEGS = 4;
    localparam int W        = SEG_LEN * NUM_SEGS;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a_in, b_in;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;

    int n_tests = 0;
    int n_fail  = 0;

    cpa_sequencer #(.SEG_LEN(SEG_LEN), .NUM_SEGS(NUM_SEGS)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a_in(a_in), .b_in(b_in), .cin(cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W:0] got, input logic [W:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference latency: the early-terminating build stops after the first segment
    // whose carry-out is 0 with all higher operand segments zero.
    function automatic int exp_lat(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
`ifdef CPA_SEQUENCER_EARLY_TERM_EN
        logic [SEG_LEN:0] t;
        logic             c;
        logic [W-1:0]     hi;
        c = ci;
        for (int i = 0; i < NUM_SEGS - 1; i++) begin
            t  = {1'b0, a[i*SEG_LEN +: SEG_LEN]} + {1'b0, b[i*SEG_LEN +: SEG_LEN]} + {{SEG_LEN{1'b0}}, c};
            c  = t[SEG_LEN];
            hi = (a | b) >> ((i + 1) * SEG_LEN);
            if (!c && hi == '0) return i + 1;
        end
        return NUM_SEGS;
`else
        return NUM_SEGS + 0 * int'(a[0] ^ b[0] ^ ci);
`endif
    endfunction

    // Called one time unit after a rising edge with the DUT in IDLE.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic ci, input int hold, input bit hold_valid);
        logic [W:0] exp;
        int         lat;
        exp = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
        chk({tag, "_in_ready_idle"}, in_ready, 1);
        a_in     = a;
        b_in     = b;
        cin      = ci;
        in_valid = 1'b1;
        @(posedge clk); #1;
        if (!hold_valid) in_valid = 1'b0;
        chk({tag, "_busy"}, busy, 1);
        lat = 0;
        while (!out_valid && lat < 40) begin
            if (hold_valid) chk({tag, "_in_ready_run"}, in_ready, 0);
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
        chk({tag, "_latency"}, lat, exp_lat(a, b, ci));
        chk({tag, "_sum"}, sum, exp[W-1:0]);
        chk({tag, "_cout"}, cout, exp[W]);
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            chk({tag, "_hold_valid"}, out_valid, 1);
            chk({tag, "_hold_sum"}, {cout, sum}, exp);
            chk({tag, "_hold_in_ready"}, in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_idle_out_valid"}, out_valid, 0);
        chk({tag, "_idle_in_ready"}, in_ready, 1);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_in      = '0;
        b_in      = '0;
        cin       = 1'b0;
        #2;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sum", {cout, sum}, '0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_op("all_ones_plus1", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 0, 1'b0);
        run_op("low_seg_carry", 64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 0, 1'b0);
        run_op("cin_only_hold_valid", 64'h0, 64'h0, 1'b1, 0, 1'b1);
        run_op("backpressure", 64'h1234_5678_9ABC_DEF0, 64'hEDCB_A987_6543_2110, 1'b0, 5, 1'b0);

        // Abort mid-RUN: accept, advance to segment index 2, then reset.
        a_in = 64'hFFFF_FFFF_FFFF_FFFF; b_in = 64'h1; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("abort_in_ready", in_ready, 1);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_sum", {cout, sum}, '0);
        chk("abort_busy", busy, 0);
        #2;
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            chk("abort_no_out_valid", out_valid, 0);
        end
        run_op("after_abort", 64'h0000_0001_0000_0000, 64'h0000_0000_FFFF_FFFF, 1'b1, 1, 1'b0);

        for (int n = 0; n < 300; n++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if (n % 3 == 0) begin
                ra = ra >> (SEG_LEN * $urandom_range(0, NUM_SEGS - 1));
                rb = rb >> (SEG_LEN * $urandom_range(0, NUM_SEGS - 1));
            end
            run_op("random", ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 2), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cpa_sequencer.md
CPA_SEQUENCER -- requirements
Module: cpa_sequencer

Interface
REQ-001 Parameter SEG_LEN, default 16: bit width of one carry-resolution segment.
REQ-002 Parameter NUM_SEGS, default 4: number of segments; operand width W = SEG_LEN*NUM_SEGS.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 in_valid  input  1  operand pair presented.
REQ-006 in_ready  output  1  block accepts operands this cycle.
REQ-007 a_in  input  W  addend A.
REQ-008 b_in  input  W  addend B.
REQ-009 cin  input  1  carry into bit 0.
REQ-010 out_valid  output  1  result held on sum/cout.
REQ-011 out_ready  input  1  consumer takes result this cycle.
REQ-012 sum  output  W  (A + B + cin) mod 2^W.
REQ-013 cout  output  1  carry out of bit W-1.
REQ-014 busy  output  1  high in RUN state.

Function
REQ-015 FSM states shall be IDLE, RUN and DONE only.
REQ-016 IDLE: in_ready=1; on in_valid&in_ready, register a_in, b_in and cin, clear segment index to 0, clear the sum register, and go to RUN.
REQ-017 RUN: each cycle one segment i computes {c, s} = A[i] + B[i] + carry using a SEG_LEN-wide generate/propagate prefix adder; s is written to sum[i] and c to the carry register.
REQ-018 RUN: the carry register initialises to the registered cin; segment i uses the carry produced by segment i-1.
REQ-019 RUN: after segment NUM_SEGS-1 is processed, cout takes the final carry and the state goes to DONE; nominal latency is exactly NUM_SEGS cycles from the accept edge to out_valid=1.
REQ-020 DONE: out_valid=1; sum and cout shall hold stable until out_valid&out_ready, then go to IDLE.
REQ-021 in_ready shall be 0 in RUN and DONE; no back-to-back overlap; minimum issue interval is NUM_SEGS+2 cycles.
REQ-022 in_valid in RUN or DONE shall be ignored, with no state change.
REQ-023 The segment index shall be a counter of width clog2(NUM_SEGS), minimum 1, and shall not wrap past NUM_SEGS-1.
REQ-024 NUM_SEGS=1 shall be legal: RUN lasts one cycle.
REQ-025 All outputs shall be registered or decoded from state only; there is no combinational in-to-out path except in_ready, which is state-decoded.

Reset
REQ-026 On rst=1, the state shall be IDLE, and in_ready=1, out_valid=0, busy=0, sum=0, cout=0, segment index=0 and carry=0, asynchronously.
REQ-027 Reset asserted in RUN or DONE shall discard the operation; no out_valid pulse shall follow.
REQ-028 The first accept shall be possible on the first rising edge after rst deasserts.

Configuration
REQ-029 Macro CPA_SEQUENCER_EARLY_TERM_EN is the only compile-time option.
REQ-030 With the macro defined, RUN shall go to DONE right after processing segment i if the produced carry=0 and all of A[i+1..NUM_SEGS-1] and B[i+1..NUM_SEGS-1] are zero; the remaining sum segments stay 0 and cout=0; latency becomes i+1 cycles.
REQ-031 With the macro undefined, latency shall always be NUM_SEGS cycles; the early-termination logic shall be absent.
REQ-032 The sum and cout values shall be identical with and without the macro.

Verification (SEG_LEN=16, NUM_SEGS=4)
REQ-033 A=0xFFFF_FFFF_FFFF_FFFF, B=0x1, cin=0 -> sum=0x0, cout=1, out_valid exactly 4 cycles after accept (both builds).
REQ-034 A=0x0000_0000_0000_FFFF, B=0x1, cin=0 -> sum=0x0000_0000_0001_0000, cout=0; latency 4 without macro, 2 with CPA_SEQUENCER_EARLY_TERM_EN.
REQ-035 A=B=0, cin=1 -> sum=0x1, cout=0; in_valid held high in RUN causes no second accept.
REQ-036 A=0x1234_5678_9ABC_DEF0, B=0xEDCB_A987_6543_2110, out_ready low 5 cycles in DONE -> sum=0x0, cout=1 held stable, in_ready=0 throughout; IDLE the cycle after out_ready=1.
REQ-037 rst pulsed with index=2 in RUN -> next cycle in_ready=1, out_valid=0, sum=0; a new operation then completes correctly.
REQ-038 Random A/B/cin, 10k operations with random out_ready -> sum/cout match the W+1-bit reference add, in both builds.
